// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link: slot geometry, receiver state encoding
// and the slot one-hot decode used by both the transmit select and the receive lane_sel.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    slot_onehot       = '0;
    slot_onehot[slot] = 1'b1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter with clear / load-to-1 controls and a one-hot lane select
// that is forced to zero while the receiver is not active (hunting).
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 load1,
  input  logic                 clear,
  input  logic                 active,
  output logic [SLOT_W-1:0]    slot,
  output logic [NUM_SLOTS-1:0] lane_sel
);

  logic [SLOT_W-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (clear) begin
      slot_q <= '0;
    end else if (load1) begin
      slot_q <= SLOT_W'(1);
    end else if (inc) begin
      slot_q <= slot_q + 1'b1;
    end
  end

  assign slot     = slot_q;
  assign lane_sel = active ? slot_onehot(slot_q) : '0;

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM link: frame tracking, shadow capture and registered
// per-frame channel outputs. Define TDM_DEMUX_ERRCNT_EN to add the saturating err_cnt port.
module tdm_demux4 #(
  parameter int unsigned DW        = 1,
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          en,
  input  logic          sync,
  output logic [DW-1:0] Y0,
  output logic [DW-1:0] Y1,
  output logic [DW-1:0] Y2,
  output logic [DW-1:0] Y3,
  output logic          frame_valid,
  output logic [3:0]    lane_sel,
  output logic          locked,
  output logic          sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  import tdm_pkg::*;

  if (NUM_SLOTS != tdm_pkg::NUM_SLOTS) begin : g_bad_num_slots
    $error("tdm_demux4: NUM_SLOTS must be 4");
  end

  state_e            state_q;
  logic [SLOT_W-1:0] slot;
  logic [DW-1:0]     shadow_q [3];
  logic [DW-1:0]     y_q [4];
  logic              frame_valid_q, sync_err_q;

  logic ctr_inc, ctr_load1, ctr_clear;
  logic early, missing, last, shadow_we;

  // Decode the current beat; only one of early/missing/last can be set.
  always_comb begin
    ctr_inc   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clear = 1'b0;
    early     = 1'b0;
    missing   = 1'b0;
    last      = 1'b0;
    shadow_we = 1'b0;
    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            ctr_load1 = 1'b1;
            shadow_we = 1'b1;
          end
        end
        StLock: begin
          if (sync && slot != '0) begin
            early     = 1'b1;
            ctr_load1 = 1'b1;
            shadow_we = 1'b1;
          end else if (!sync && slot == '0) begin
            missing   = 1'b1;
            ctr_clear = 1'b1;
          end else begin
            ctr_inc   = 1'b1;
            last      = (slot == SLOT_W'(NUM_SLOTS - 1));
            shadow_we = !last;
          end
        end
        default: ;
      endcase
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (ctr_inc),
    .load1    (ctr_load1),
    .clear    (ctr_clear),
    .active   (state_q == StLock),
    .slot     (slot),
    .lane_sel (lane_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StHunt;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
    end else begin
      frame_valid_q <= last;
      sync_err_q    <= early | missing;
      if (en && state_q == StHunt && sync) state_q <= StLock;
      if (missing) state_q <= StHunt;
      // Hunt and early-sync beats always land at slot 0 (counter is 0 or being reloaded).
      for (int i = 0; i < 3; i++) begin
        if (shadow_we && (early ? '0 : slot) == SLOT_W'(i)) shadow_q[i] <= din;
      end
      if (last) begin
        y_q[0] <= shadow_q[0];
        y_q[1] <= shadow_q[1];
        y_q[2] <= shadow_q[2];
        y_q[3] <= din;
      end
    end
  end

  assign Y0          = y_q[0];
  assign Y1          = y_q[1];
  assign Y2          = y_q[2];
  assign Y3          = y_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == StLock);

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((early || missing) && err_cnt_q != 8'hff) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboarded bench for tdm_demux4: expected frames are queued as slot-3 beats are driven
// and compared whenever frame_valid is seen.
module tb_tdm_demux4;

  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;
    logic [DW-1:0] y2;
    logic [DW-1:0] y3;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          en;
  logic          sync;
  logic [DW-1:0] Y0, Y1, Y2, Y3;
  logic          frame_valid;
  logic [3:0]    lane_sel;
  logic          locked;
  logic          sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  tdm_demux4 #(
    .DW        (DW),
    .NUM_SLOTS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .Y0          (Y0),
    .Y1          (Y1),
    .Y2          (Y2),
    .Y3          (Y3),
    .frame_valid (frame_valid),
    .lane_sel    (lane_sel),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     err_seen = 0;
  int     exp_err  = 0;
  frame_t exp_q[$];
  frame_t mon_f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One strobed beat: driven on the falling edge, returns just after the sampling edge.
  task automatic beat(input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    din  = d;
    sync = s;
    en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic push(input logic [DW-1:0] a, b, c, d);
    frame_t f;
    f = '{y0: a, y1: b, y2: c, y3: d};
    exp_q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sync_err) err_seen++;
      if (frame_valid || sync_err) check_eq("fv_err_excl", 32'(frame_valid & sync_err), 32'd0);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("fv_unexpected", 32'(frame_valid), 32'd0);
        end else begin
          mon_f = exp_q.pop_front();
          check_eq("y_frame", {16'd0, Y0, Y1, Y2, Y3}, {16'd0, mon_f});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    din  = '0;
    #12;
    check_eq("rst_y", {Y0, Y1, Y2, Y3}, 32'd0);
    check_eq("rst_fv", 32'(frame_valid), 32'd0);
    check_eq("rst_lane", 32'(lane_sel), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err", 32'(sync_err), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
    check_eq("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Clean frame
    beat(4'hA, 1'b1);
    check_eq("t1_locked", 32'(locked), 32'd1);
    check_eq("t1_lane1", 32'(lane_sel), 32'h2);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    push(4'hA, 4'hB, 4'hC, 4'hD);
    beat(4'hD, 1'b0);
    check_eq("t1_fv", 32'(frame_valid), 32'd1);
    check_eq("t1_y", {Y0, Y1, Y2, Y3}, 32'hABCD);
    check_eq("t1_lane0", 32'(lane_sel), 32'h1);
    gap(1);
    @(posedge clk);
    #1;
    check_eq("t1_fv_pulse", 32'(frame_valid), 32'd0);

    // Gapped strobe
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      check_eq("t2_lane_gap", 32'(lane_sel), 32'h4);
      check_eq("t2_no_fv", 32'(frame_valid), 32'd0);
    end
    beat(4'h3, 1'b0);
    push(4'h1, 4'h2, 4'h3, 4'h4);
    beat(4'h4, 1'b0);
    check_eq("t2_fv", 32'(frame_valid), 32'd1);
    check_eq("t2_y", {Y0, Y1, Y2, Y3}, 32'h1234);

    // Early sync
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'hE, 1'b1);
    exp_err++;
    check_eq("t3_err", 32'(sync_err), 32'd1);
    check_eq("t3_locked", 32'(locked), 32'd1);
    check_eq("t3_lane", 32'(lane_sel), 32'h2);
    check_eq("t3_y_hold", {Y0, Y1, Y2, Y3}, 32'h1234);
    beat(4'h6, 1'b0);
    check_eq("t3_err_pulse", 32'(sync_err), 32'd0);
    beat(4'h7, 1'b0);
    push(4'hE, 4'h6, 4'h7, 4'h8);
    beat(4'h8, 1'b0);
    check_eq("t3_y", {Y0, Y1, Y2, Y3}, 32'hE678);

    // Missing sync, then relock
    beat(4'h9, 1'b0);
    exp_err++;
    check_eq("t4_err", 32'(sync_err), 32'd1);
    check_eq("t4_locked", 32'(locked), 32'd0);
    check_eq("t4_lane", 32'(lane_sel), 32'h0);
    check_eq("t4_y_hold", {Y0, Y1, Y2, Y3}, 32'hE678);
    beat(4'h5, 1'b0);
    check_eq("t4_hunt_noerr", 32'(sync_err), 32'd0);
    check_eq("t4_hunt_unlocked", 32'(locked), 32'd0);
    beat(4'h1, 1'b1);
    check_eq("t4_relock", 32'(locked), 32'd1);
    beat(4'h2, 1'b0);
    beat(4'h3, 1'b0);
    push(4'h1, 4'h2, 4'h3, 4'hF);
    beat(4'hF, 1'b0);
    check_eq("t4_y", {Y0, Y1, Y2, Y3}, 32'h123F);
    check_eq("t4_err_count", 32'(err_seen), 32'(exp_err));

    // Asynchronous reset mid-frame
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    beat(4'hC, 1'b0);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_y", {Y0, Y1, Y2, Y3}, 32'd0);
    check_eq("t5_locked", 32'(locked), 32'd0);
    check_eq("t5_lane", 32'(lane_sel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beat(4'hD, 1'b0);
    check_eq("t5_hunt_noerr", 32'(sync_err), 32'd0);
    check_eq("t5_hunt_nofv", 32'(frame_valid), 32'd0);

`ifdef TDM_DEMUX_ERRCNT_EN
    check_eq("t6_errcnt_rst", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 260; i++) begin
      beat(4'h0, 1'b1);
      beat(4'h1, 1'b0);
      beat(4'h2, 1'b0);
      push(4'h0, 4'h1, 4'h2, 4'h3);
      beat(4'h3, 1'b0);
      beat(4'h4, 1'b0);
      exp_err++;
      check_eq("t6_errcnt", 32'(err_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
`endif

    gap(3);
    check_eq("final_err_count", 32'(err_seen), 32'(exp_err));
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
